la_upload_reader: RTL and testbench

- Drain side of the logic-analyser capture path.
- After a capture completes (dout_done rises), reads the packed 256-bit sample words back out of the capture FIFO and serialises them LSB-byte-first into a byte stream (valid/ready) feeding the Ethernet UDP transmitter.
- Sends exactly sample_num bytes, marks packet boundaries with tx_last, then raises ethernet_read_done, which re-arms the capture block.

---
 rtl/la_pkg.sv | 7 +
 rtl/la_word_serializer.sv | 45 ++++
 rtl/la_upload_reader.sv | 92 +++++++++
 tb/tb_la_upload_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// la_pkg: shared FSM encoding, default geometry and byte-lane order for the upload reader
package la_pkg;
  localparam int DEF_MEM_DQ_WIDTH = 32;
  localparam int DEF_PKT_BYTES = 1024;
  localparam bit LSB_BYTE_FIRST = 1'b1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
endpackage

// File: rtl/la_word_serializer.sv
// la_word_serializer: holds one FIFO word and presents it byte by byte on a valid/ready stream
//   load      : capture word, restart at lane 0 and raise tx_valid
//   stop      : drop tx_valid (word finished or upload finished)
//   advance   : step to the next byte after a handshake
//   tx_data   : current byte, tx_valid: byte present
//   byte_idx  : index of the byte being presented, last_lane: byte_idx is the final lane
module la_word_serializer
  import la_pkg::*;
#(
  parameter int MEM_DQ_WIDTH = DEF_MEM_DQ_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [MEM_DQ_WIDTH*8-1:0]       word,
  input  logic                            stop,
  input  logic                            advance,
  output logic                            tx_valid,
  output logic [7:0]                      tx_data,
  output logic [$clog2(MEM_DQ_WIDTH)-1:0] byte_idx,
  output logic                            last_lane
);
  localparam int IW = $clog2(MEM_DQ_WIDTH);
  logic [MEM_DQ_WIDTH*8-1:0] word_r;
  logic [IW-1:0]             lane;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r   <= '0;
      byte_idx <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      word_r   <= word;
      byte_idx <= '0;
      tx_valid <= 1'b1;
    end else if (stop) begin
      tx_valid <= 1'b0;
    end else if (advance) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end
  // tx_data follows the registered word/index, so it is stable for as long as the index holds
  assign lane      = LSB_BYTE_FIRST ? byte_idx : IW'(MEM_DQ_WIDTH - 1) - byte_idx;
  assign tx_data   = word_r[{lane, 3'b000} +: 8];
  assign last_lane = byte_idx == IW'(MEM_DQ_WIDTH - 1);
endmodule

// File: rtl/la_upload_reader.sv
// la_upload_reader: drains captured FIFO words into a packetised LSB-first byte stream
//   dout_done/sample_num : capture complete level and byte count to upload
//   fifo_rdata/empty/ren : non-show-ahead FIFO read port
//   tx_data/valid/ready/last : byte stream to the UDP transmitter
//   ethernet_read_done   : high while idle, low while an upload is running
module la_upload_reader
  import la_pkg::*;
#(
  parameter int MEM_DQ_WIDTH = DEF_MEM_DQ_WIDTH,
  parameter int PKT_BYTES    = DEF_PKT_BYTES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dout_done,
  input  logic [31:0]               sample_num,
  input  logic [MEM_DQ_WIDTH*8-1:0] fifo_rdata,
  input  logic                      fifo_empty,
  output logic                      fifo_ren,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic                      ethernet_read_done
);
  localparam int IW = $clog2(MEM_DQ_WIDTH);
  localparam int PW = $clog2(PKT_BYTES);
  state_t        state, nxt;
  logic          dout_done_d1;
  logic [31:0]   total, byte_cnt;
  logic [PW-1:0] pkt_cnt;
  logic [IW-1:0] byte_idx;
  logic          start, go, hs, final_byte, last_lane, load, stop, advance;
  assign start      = dout_done && !dout_done_d1;
  assign go         = state == IDLE && start && sample_num != 32'd0;
  assign hs         = tx_valid && tx_ready;
  assign final_byte = byte_cnt == total - 32'd1;
  assign tx_last    = tx_valid && (pkt_cnt == PW'(PKT_BYTES - 1) || final_byte);
  // Read strobe is taken straight from FETCH so the word lands exactly in LOAD
  assign fifo_ren   = state == FETCH && !fifo_empty;
  assign load       = state == LOAD;
  assign stop       = state == SEND && hs && (final_byte || last_lane);
  assign advance    = state == SEND && hs && !stop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? FETCH : IDLE;
      FETCH:   nxt = fifo_empty ? FETCH : LOAD;
      LOAD:    nxt = SEND;
      SEND:    nxt = !hs ? SEND : final_byte ? DONE : last_lane ? FETCH : SEND;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_done_d1       <= 1'b1;
      total              <= '0;
      byte_cnt           <= '0;
      pkt_cnt            <= '0;
      ethernet_read_done <= 1'b1;
    end else begin
      dout_done_d1 <= dout_done;
      if (go) begin
        total              <= sample_num;
        byte_cnt           <= '0;
        pkt_cnt            <= '0;
        ethernet_read_done <= 1'b0;
      end
      if (state == SEND && hs) begin
        byte_cnt <= byte_cnt + 32'd1;
        pkt_cnt  <= tx_last ? '0 : pkt_cnt + 1'b1;
      end
      if (state == DONE) ethernet_read_done <= 1'b1;
    end
  end
  la_word_serializer #(.MEM_DQ_WIDTH(MEM_DQ_WIDTH)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .word      (fifo_rdata),
    .stop      (stop),
    .advance   (advance),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .byte_idx  (byte_idx),
    .last_lane (last_lane)
  );
endmodule

// File: tb/tb_la_upload_reader.sv
// tb_la_upload_reader: randomized scoreboard bench for la_upload_reader
module tb_la_upload_reader;
  localparam int W  = 32;
  localparam int PB = 16;
  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  logic             clk = 0, rst_n = 0, dout_done = 0, tx_ready = 1, force_empty = 0;
  logic [31:0]      sample_num = 0;
  logic [W*8-1:0]   fifo_rdata = '0;
  logic             fifo_empty, fifo_ren, tx_valid, tx_last, erd;
  logic [7:0]       tx_data;
  logic [W*8-1:0]   mem[$];
  logic [W*8-1:0]   mdl[$];
  exp_t             exp_q[$];
  exp_t             e;
  int               rp = 0, wr_cnt = 0, rdy_mode = 0;
  int               total_c = 0, bad = 0, ren_cnt = 0, val_cnt = 0, hs_cnt = 0, pend = 0;
  logic             prev_stall = 0, pl = 0;
  logic [7:0]       pd = 0;

  always #5 clk = ~clk;

  la_upload_reader #(.MEM_DQ_WIDTH(W), .PKT_BYTES(PB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .dout_done          (dout_done),
    .sample_num         (sample_num),
    .fifo_rdata         (fifo_rdata),
    .fifo_empty         (fifo_empty),
    .fifo_ren           (fifo_ren),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .tx_last            (tx_last),
    .ethernet_read_done (erd)
  );

  assign fifo_empty = force_empty || (rp >= wr_cnt);
  always @(posedge clk) if (fifo_ren) begin
    fifo_rdata <= mem[rp];
    rp         <= rp + 1;
  end

  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total_c++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      pend = 0;
    end else begin
      if (fifo_ren) ren_cnt++;
      if (tx_valid) val_cnt++;
      if (pend == 2) begin chk("erd_high_after_done", erd, 1); pend = 0; end
      if (pend == 1) begin chk("erd_low_in_done", erd, 0); pend = 2; end
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, pd);
        chk("stall_last", tx_last, pl);
      end
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", tx_data, e.d);
          chk("last", tx_last, e.l);
          if (exp_q.size() == 0) pend = 1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      pd = tx_data;
      pl = tx_last;
    end
  end

  function automatic logic [W*8-1:0] mkword(input int base, input bit rnd);
    logic [W*8-1:0] w;
    for (int k = 0; k < W; k++) w[8*k +: 8] = rnd ? 8'($urandom) : 8'(base + k);
    return w;
  endfunction

  task automatic push_word(input logic [W*8-1:0] w);
    mem.push_back(w);
    wr_cnt++;
    mdl.push_back(w);
  endtask

  task automatic expect_upload(input int n);
    logic [W*8-1:0] cur;
    exp_t x;
    cur = '0;
    for (int j = 0; j < n; j++) begin
      if (j % W == 0) cur = mdl.pop_front();
      x.d = cur[8*(j % W) +: 8];
      x.l = (j % PB == PB - 1) || (j == n - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic run(input int n, input bit stall);
    int r0, to;
    expect_upload(n);
    r0 = ren_cnt;
    if (stall) force_empty = 1;
    @(posedge clk); #2;
    sample_num = n;
    dout_done = 1;
    @(posedge clk);
    @(negedge clk);
    chk("erd_low_after_start", erd, 0);
    if (stall) begin
      repeat (20) begin
        @(negedge clk);
        chk("empty_no_ren", fifo_ren, 0);
        chk("empty_no_valid", tx_valid, 0);
      end
      @(posedge clk); #2;
      force_empty = 0;
    end
    to = 0;
    while ((exp_q.size() != 0 || erd !== 1'b1) && to < 5000) begin
      @(negedge clk);
      to++;
    end
    chk("upload_timeout", to < 5000, 1);
    repeat (4) @(negedge clk);
    chk("ren_pulses", ren_cnt - r0, (n + W - 1) / W);
    @(posedge clk); #2;
    dout_done = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ren"}, fifo_ren, 0);
    chk({nm, "_valid"}, tx_valid, 0);
    chk({nm, "_last"}, tx_last, 0);
    chk({nm, "_data"}, tx_data, 0);
    chk({nm, "_erd"}, erd, 1);
  endtask

  initial begin
    logic [W*8-1:0] w1, w2;
    int r0, v0, h0, to;
    repeat (3) @(posedge clk); #2;
    chk_reset_outs("por");
    rst_n = 1;
    repeat (2) @(posedge clk);
    push_word(mkword(0, 0)); push_word(mkword(32, 0));
    run(64, 0);
    push_word(mkword(0, 0)); push_word(mkword(32, 0));
    run(40, 0);
    push_word(mkword(0, 1)); push_word(mkword(0, 1));
    run(40, 0);
    rdy_mode = 1;
    push_word(mkword(0, 0)); push_word(mkword(32, 0)); push_word(mkword(64, 0));
    run(96, 0);
    push_word(mkword(0, 1)); push_word(mkword(0, 1)); push_word(mkword(0, 1));
    run(70, 0);
    rdy_mode = 0;
    push_word(mkword(0, 1)); push_word(mkword(0, 1));
    run(64, 1);
    r0 = ren_cnt; v0 = val_cnt;
    @(posedge clk); #2;
    sample_num = 0;
    dout_done = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("zero_no_ren", ren_cnt - r0, 0);
    chk("zero_no_valid", val_cnt - v0, 0);
    chk("zero_erd", erd, 1);
    @(posedge clk); #2;
    dout_done = 0;
    repeat (3) @(posedge clk);
    w1 = mkword(0, 1); w2 = mkword(0, 1);
    push_word(mkword(0, 1)); push_word(w1); push_word(w2);
    expect_upload(96);
    h0 = hs_cnt;
    @(posedge clk); #2;
    sample_num = 96;
    dout_done = 1;
    to = 0;
    while (hs_cnt < h0 + 10 && to < 1000) begin @(negedge clk); to++; end
    chk("reset_wait_timeout", to < 1000, 1);
    @(posedge clk); #2;
    rst_n = 0;
    exp_q.delete();
    #1;
    chk_reset_outs("midrst");
    repeat (2) @(posedge clk); #2;
    rst_n = 1;
    r0 = ren_cnt; v0 = val_cnt;
    #1;
    chk_reset_outs("postrst");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("postrst_no_ren", ren_cnt - r0, 0);
    chk("postrst_no_valid", val_cnt - v0, 0);
    chk("postrst_erd", erd, 1);
    mdl.delete();
    mdl.push_back(w1); mdl.push_back(w2);
    @(posedge clk); #2;
    dout_done = 0;
    repeat (2) @(posedge clk);
    run(64, 0);
    $display("test done: total=%0d bad=%0d", total_c, bad);
    $finish;
  end
endmodule
